line_fill_unit: RTL and testbench

- Memory-side refill engine directly downstream of the instruction-cache controller.
- Takes the controller's fill request (mem_rd, w_sel) and the miss address, and fetches the whole line from the backing memory bus into an internal line buffer.
- Presents each requested word with mem_ready, and holds it until the cache reports write_done.
- Buffers the line so the second-word fill is served without another bus round trip.

---
 rtl/line_fill_unit_pkg.sv | 22 ++
 rtl/line_fill_unit_line_buffer.sv | 54 +++++
 rtl/line_fill_unit.sv | 175 +++++++++++++++++
 tb/tb_line_fill_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_fill_unit_pkg.sv
// Shared definitions for the instruction-cache line fill unit: FSM encoding,
// default bus timeout and address-field width helpers.
package line_fill_unit_pkg;

  typedef logic [1:0] lfu_state_t;

  localparam lfu_state_t ST_IDLE  = 2'd0;
  localparam lfu_state_t ST_FETCH = 2'd1;
  localparam lfu_state_t ST_DONE  = 2'd2;

  localparam int unsigned LFU_DEF_TIMEOUT = 255;

  function automatic int unsigned lfu_sel_w(input int unsigned words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

  // Tag is everything above the word index and the 2-bit byte offset.
  function automatic int unsigned lfu_tag_w(input int unsigned addr_w, input int unsigned sel_w);
    return addr_w - sel_w - 2;
  endfunction

endpackage

// File: rtl/line_fill_unit_line_buffer.sv
// One-line refill buffer: word storage, per-word valid bits, tag register and
// a read mux that forwards a same-cycle write to the selected word.
module line_buffer import line_fill_unit_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 2,
  parameter int unsigned SEL_W  = lfu_sel_w(WORDS),
  parameter int unsigned TAG_W  = 29
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              tag_load_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              wr_en_i,
  input  logic [SEL_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [TAG_W-1:0]  cmp_tag_i,
  input  logic [SEL_W-1:0]  rd_idx_i,
  output logic              tag_match_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic [DATA_W-1:0] data_q [WORDS];
  logic [WORDS-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic              fwd;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      if (tag_load_i) tag_q <= tag_i;
      if (clear_i) valid_q <= '0;
      else if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Payload needs no reset: a word is never read without its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en_i) data_q[wr_idx_i] <= wr_data_i;
  end

  always_comb begin
    fwd         = wr_en_i && (wr_idx_i == rd_idx_i);
    rd_valid_o  = valid_q[rd_idx_i] | fwd;
    rd_data_o   = fwd ? wr_data_i : data_q[rd_idx_i];
    tag_match_o = (tag_q == cmp_tag_i);
    tag_o       = tag_q;
  end

endmodule

// File: rtl/line_fill_unit.sv
// Refill engine between the I-cache controller and the backing memory bus:
// fetches a whole line into line_buffer and presents it word by word.
module line_fill_unit import line_fill_unit_pkg::*; #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 2,
  parameter int unsigned SEL_W          = $clog2(WORDS_PER_LINE),
  parameter int unsigned TIMEOUT        = LFU_DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic [SEL_W-1:0]  w_sel,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              write_done,
  input  logic              flush,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              fill_err
);

  localparam int unsigned TAG_W = lfu_tag_w(ADDR_W, SEL_W);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(WORDS_PER_LINE - 1);

  lfu_state_t        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              bus_req_q, bus_req_d;
  logic              err_q, err_d;
  logic              line_valid_q, line_valid_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              consumed_q, consumed_d;
  logic [SEL_W-1:0]  wsel_q;

  logic              buf_clear, tag_load, wr_en;
  logic              tag_match, rd_valid, flush_blk, wsel_chg;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  req_tag, cur_tag;
  logic [SEL_W+1:0]  unused_offset;

  assign req_tag       = miss_addr[ADDR_W-1:SEL_W+2];
  assign unused_offset = miss_addr[SEL_W+1:0];

  line_buffer #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS_PER_LINE),
    .SEL_W  (SEL_W),
    .TAG_W  (TAG_W)
  ) u_line_buffer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (buf_clear),
    .tag_load_i  (tag_load),
    .tag_i       (req_tag),
    .wr_en_i     (wr_en),
    .wr_idx_i    (idx_q),
    .wr_data_i   (bus_rdata),
    .cmp_tag_i   (req_tag),
    .rd_idx_i    (w_sel),
    .tag_match_o (tag_match),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .tag_o       (cur_tag)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    bus_req_d    = bus_req_q;
    err_d        = 1'b0;
    line_valid_d = line_valid_q;
    buf_clear    = 1'b0;
    tag_load     = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          line_valid_d = 1'b0;
          buf_clear    = 1'b1;
        end
        if (mem_rd && (flush || !line_valid_q || !tag_match)) begin
          line_valid_d = 1'b0;
          buf_clear    = 1'b1;
          tag_load     = 1'b1;
          idx_d        = '0;
          tmo_d        = '0;
          bus_req_d    = 1'b1;
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus_ack) begin
          wr_en = 1'b1;
          tmo_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            bus_req_d    = 1'b0;
            line_valid_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d        = 1'b1;
          buf_clear    = 1'b1;
          line_valid_d = 1'b0;
          bus_req_d    = 1'b0;
          tmo_d        = '0;
          idx_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        if (flush) begin
          line_valid_d = 1'b0;
          buf_clear    = 1'b1;
        end
        if (!mem_rd) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A consumed word stays hidden until w_sel moves or the request ends.
  always_comb begin
    flush_blk  = flush && (state_q != ST_FETCH);
    wsel_chg   = (w_sel != wsel_q);
    consumed_d = mem_rd && !wsel_chg && (consumed_q || (write_done && ready_q));
    ready_d    = mem_rd && rd_valid && tag_match && !consumed_d && !flush_blk;
    data_d     = ready_d ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      tmo_q        <= '0;
      bus_req_q    <= 1'b0;
      err_q        <= 1'b0;
      line_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      data_q       <= '0;
      consumed_q   <= 1'b0;
      wsel_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      bus_req_q    <= bus_req_d;
      err_q        <= err_d;
      line_valid_q <= line_valid_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      consumed_q   <= consumed_d;
      wsel_q       <= w_sel;
    end
  end

  assign mem_ready = ready_q;
  assign mem_data  = data_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = {cur_tag, idx_q, 2'b00};
  assign fill_err  = err_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: directed refill scenarios followed by
// randomized requests against a line-level model of the buffer contents.
module tb_line_fill_unit;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset, mem_rd, write_done, flush, bus_ack;
  logic [0:0]  w_sel;
  logic [31:0] miss_addr, bus_rdata;
  logic        mem_ready, bus_req, fill_err;
  logic [31:0] mem_data, bus_addr;

  int unsigned n_chk = 0, n_pass = 0;
  logic [31:0] salt;
  logic [31:0] addr_log[$];
  bit          resp_en = 1'b1, resp_rand = 1'b0;
  int          resp_lat = 2;

  always #5 clk = ~clk;

  line_fill_unit #(
    .ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .w_sel(w_sel),
    .miss_addr(miss_addr), .write_done(write_done), .flush(flush),
    .mem_ready(mem_ready), .mem_data(mem_data), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .fill_err(fill_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hAAAA_0000;
    if (a == 32'h0000_1004) return 32'hBBBB_0001;
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Backing memory: acks each request after a programmable number of cycles.
  initial begin
    int wait_cnt = -1;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        bus_ack = 1'b0;
        wait_cnt = -1;
      end else if (resp_en && bus_req) begin
        if (wait_cnt < 0) wait_cnt = resp_rand ? int'($urandom_range(0, 3)) : resp_lat;
        if (wait_cnt == 0) begin
          bus_ack = 1'b1;
          bus_rdata = mem_word(bus_addr);
          addr_log.push_back(bus_addr);
          wait_cnt = -1;
        end else wait_cnt--;
      end else wait_cnt = -1;
    end
  end

  task automatic wait_ready(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 40 && !mem_ready; i++) cyc();
    if (!mem_ready) check_eq({tag, "_rdy"}, mem_ready, 1);
    else check_eq({tag, "_data"}, mem_data, exp);
  endtask

  task automatic consume();
    write_done = 1'b1;
    cyc();
    write_done = 1'b0;
  endtask

  task automatic idle_gap();
    mem_rd = 1'b0;
    w_sel = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic check_log(input string tag, input logic [31:0] base);
    check_eq({tag, "_nreq"}, addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check_eq({tag, "_addr0"}, addr_log[0], base);
      check_eq({tag, "_addr1"}, addr_log[1], base + 32'd4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    bit seen, model_valid, need_fill;
    logic [31:0] model_line, line, a;
    salt = $urandom;
    reset = 1'b1; mem_rd = 1'b0; write_done = 1'b0; flush = 1'b0;
    w_sel = 1'b0; miss_addr = '0;
    repeat (3) cyc();
    check_eq("rst_ready", mem_ready, 0);
    check_eq("rst_data", mem_data, 0);
    check_eq("rst_busreq", bus_req, 0);
    check_eq("rst_busaddr", bus_addr, 0);
    check_eq("rst_err", fill_err, 0);
    reset = 1'b0;

    // Cold fill
    addr_log.delete();
    miss_addr = 32'h0000_1004; mem_rd = 1'b1;
    cyc();
    check_eq("cold_req_lat", bus_req, 1);
    check_eq("cold_addr0", bus_addr, 32'h1000);
    for (int i = 0; i < 40 && !mem_ready; i++) cyc();
    check_eq("cold_fwd_lat", bus_ack, 1);
    wait_ready("cold_w0", 32'hAAAA_0000);
    consume();
    check_eq("cold_consumed", mem_ready, 0);
    w_sel = 1'b1;
    wait_ready("cold_w1", 32'hBBBB_0001);
    consume();
    idle_gap();
    check_eq("cold_busidle", bus_req, 0);
    check_log("cold", 32'h1000);

    // Line reuse
    addr_log.delete();
    miss_addr = 32'h0000_1000; mem_rd = 1'b1;
    cyc();
    check_eq("reuse_ready", mem_ready, 1);
    check_eq("reuse_data", mem_data, 32'hAAAA_0000);
    check_eq("reuse_nobus", bus_req, 0);
    consume();
    w_sel = 1'b1;
    wait_ready("reuse_w1", 32'hBBBB_0001);
    consume();
    idle_gap();
    check_eq("reuse_nreq", addr_log.size(), 0);

    // New line
    addr_log.delete();
    miss_addr = 32'h0000_2000; mem_rd = 1'b1;
    cyc();
    check_eq("new_nostale", mem_ready, 0);
    wait_ready("new_w0", mem_word(32'h2000));
    consume();
    w_sel = 1'b1;
    wait_ready("new_w1", mem_word(32'h2004));
    consume();
    idle_gap();
    check_log("new", 32'h2000);

    // Bus timeout
    resp_en = 1'b0;
    miss_addr = 32'h0000_3000; mem_rd = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (fill_err) seen = 1'b1;
      else if (bus_req) n++;
    end
    check_eq("tmo_err", fill_err, 1);
    check_eq("tmo_cycles", n, TMO);
    check_eq("tmo_busdrop", bus_req, 0);
    mem_rd = 1'b0;
    cnt = 0;
    repeat (6) begin
      cyc();
      if (fill_err || bus_req) cnt++;
    end
    check_eq("tmo_single_pulse", cnt, 0);
    resp_en = 1'b1;
    addr_log.delete();
    mem_rd = 1'b1;
    wait_ready("tmo_w0", mem_word(32'h3000));
    consume();
    w_sel = 1'b1;
    wait_ready("tmo_w1", mem_word(32'h3004));
    consume();
    idle_gap();
    check_log("tmo_refetch", 32'h3000);

    // Reset mid-fill
    addr_log.delete();
    miss_addr = 32'h0000_4000; mem_rd = 1'b1;
    for (int i = 0; i < 40 && addr_log.size() == 0; i++) cyc();
    check_eq("midrst_first_ack", addr_log.size(), 1);
    reset = 1'b1;
    cyc();
    check_eq("midrst_busreq", bus_req, 0);
    check_eq("midrst_busaddr", bus_addr, 0);
    check_eq("midrst_ready", mem_ready, 0);
    check_eq("midrst_data", mem_data, 0);
    check_eq("midrst_err", fill_err, 0);
    addr_log.delete();
    reset = 1'b0;
    wait_ready("midrst_w0", mem_word(32'h4000));
    consume();
    w_sel = 1'b1;
    wait_ready("midrst_w1", mem_word(32'h4004));
    consume();
    check_log("midrst", 32'h4000);

    // Handshake and flush while the line is complete
    w_sel = 1'b0;
    cyc();
    check_eq("hs_ready", mem_ready, 1);
    check_eq("hs_data", mem_data, mem_word(32'h4000));
    consume();
    cnt = 0;
    repeat (3) begin
      if (mem_ready) cnt++;
      cyc();
    end
    check_eq("hs_held_low", cnt, 0);
    w_sel = 1'b1;
    cyc();
    check_eq("hs_wsel_rearm", mem_ready, 1);
    check_eq("hs_wsel_data", mem_data, mem_word(32'h4004));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("flush_ready", mem_ready, 0);
    idle_gap();
    addr_log.delete();
    mem_rd = 1'b1;
    wait_ready("flush_w0", mem_word(32'h4000));
    consume();
    w_sel = 1'b1;
    wait_ready("flush_w1", mem_word(32'h4004));
    consume();
    idle_gap();
    check_log("flush", 32'h4000);

    // Randomized requests against a one-line model
    resp_rand = 1'b1;
    model_valid = 1'b1;
    model_line = 32'h4000;
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        model_valid = 1'b0;
      end
      case ($urandom_range(0, 3))
        0: line = 32'h5000;
        1: line = 32'h6000;
        2: line = model_line;
        default: line = $urandom & 32'hFFFF_FFF8;
      endcase
      a = line | ($urandom & 32'h7);
      need_fill = !model_valid || (line != model_line);
      addr_log.delete();
      miss_addr = a; mem_rd = 1'b1;
      wait_ready("rnd_w0", mem_word(line));
      consume();
      w_sel = 1'b1;
      wait_ready("rnd_w1", mem_word(line + 32'd4));
      consume();
      idle_gap();
      if (need_fill) check_log("rnd_fill", line);
      else check_eq("rnd_hit_nreq", addr_log.size(), 0);
      model_valid = 1'b1;
      model_line = line;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
